// File: rtl/fib_stack_ctrl.sv
// fib_stack_ctrl: sequencer for the stack-based Fibonacci datapath.
// It computes fib(n) by expanding a tree on an external LIFO stack.
// Each popped x>=2 is replaced by pushes of x-1 and x-2.
// Each popped 1 bumps an external accumulator.
// When the stack runs empty, the accumulator holds fib(n).
//
// Ports
//   clk, clr            clock; synchronous active-high reset (also clears stack/acc externally)
//   start, n            request and operand (n latched when start is accepted in IDLE)
//   busy, done, err     status: busy outside IDLE, one-cycle done / err pulses
//   result              fib(n) after done, 0 after err; held between operations
//   acc_en, acc_clr     accumulator increment / synchronous clear
//   acc_count           accumulator value
//   stk_push, stk_din   push request and data
//   stk_pop             pop request (never together with stk_push)
//   stk_dout            combinational top of stack, valid when !stk_empty
//   stk_empty, stk_full stack status
module fib_stack_ctrl #(
    parameter int unsigned W     = 5,
    parameter int unsigned MAX_N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         acc_en,
    output logic         acc_clr,
    input  logic [W-1:0] acc_count,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [W-1:0] stk_din,
    input  logic [W-1:0] stk_dout,
    input  logic         stk_empty,
    input  logic         stk_full
);

    localparam logic [W-1:0] MAX_N_W = W'(MAX_N);
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TWO     = W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SEED,
        S_POP,
        S_PUSH_A,
        S_PUSH_B,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [W-1:0] n_reg;
    logic [W-1:0] x_reg;

    logic         n_load;
    logic         x_load;
    logic         res_load;
    logic [W-1:0] res_val;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_IDLE;
            n_reg  <= '0;
            x_reg  <= '0;
            result <= '0;
        end else begin
            state <= next_state;
            if (n_load) begin
                n_reg <= n;
            end
            if (x_load) begin
                x_reg <= stk_dout;
            end
            if (res_load) begin
                result <= res_val;
            end
        end
    end

    // Next state and state-decoded outputs.
    // Stack and accumulator outputs depend only on state and on stack/acc status, never on start.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_din    = '0;
        n_load     = 1'b0;
        x_load     = 1'b0;
        res_load   = 1'b0;
        res_val    = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    n_load = 1'b1;
                    // Out-of-range operands or a stale stack are flushed, then reported as err.
                    if ((n > MAX_N_W) || !stk_empty) begin
                        next_state = S_DRAIN;
                    end else begin
                        next_state = S_CLR;
                    end
                end
            end

            S_CLR: begin
                busy       = 1'b1;
                acc_clr    = 1'b1;
                next_state = S_SEED;
            end

            S_SEED: begin
                busy       = 1'b1;
                stk_push   = 1'b1;
                stk_din    = n_reg;
                next_state = S_POP;
            end

            S_POP: begin
                busy = 1'b1;
                if (stk_empty) begin
                    // The last acc_en was at least one cycle earlier, so acc_count is final.
                    res_load   = 1'b1;
                    res_val    = acc_count;
                    next_state = S_DONE;
                end else begin
                    stk_pop = 1'b1;
                    x_load  = 1'b1;
                    if (stk_dout == '0) begin
                        next_state = S_POP;
                    end else if (stk_dout == ONE) begin
                        acc_en     = 1'b1;
                        next_state = S_POP;
                    end else begin
                        next_state = S_PUSH_A;
                    end
                end
            end

            // x_reg >= 2 in both push states, so the subtractions cannot wrap.
            S_PUSH_A: begin
                busy = 1'b1;
                if (stk_full) begin
                    next_state = S_DRAIN;
                end else begin
                    stk_push   = 1'b1;
                    stk_din    = x_reg - ONE;
                    next_state = S_PUSH_B;
                end
            end

            S_PUSH_B: begin
                busy = 1'b1;
                if (stk_full) begin
                    next_state = S_DRAIN;
                end else begin
                    stk_push   = 1'b1;
                    stk_din    = x_reg - TWO;
                    next_state = S_POP;
                end
            end

            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = S_IDLE;
            end

            S_DRAIN: begin
                busy = 1'b1;
                if (!stk_empty) begin
                    stk_pop = 1'b1;
                end else begin
                    err        = 1'b1;
                    res_load   = 1'b1;
                    res_val    = '0;
                    next_state = S_IDLE;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Reset quiets every output in the same cycle so an abort emits no stray request.
        if (clr) begin
            next_state = S_IDLE;
            busy       = 1'b0;
            done       = 1'b0;
            err        = 1'b0;
            acc_en     = 1'b0;
            acc_clr    = 1'b0;
            stk_push   = 1'b0;
            stk_pop    = 1'b0;
            stk_din    = '0;
            n_load     = 1'b0;
            x_load     = 1'b0;
            res_load   = 1'b0;
        end
    end

endmodule
